// File: rtl/fetch_decode_stage.sv
// Fetch stage and IF/ID register feeding the immediate generator. Optional
// performance counters are included when IFD_PERF_EN is defined.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [24:0] id_imm_field,
  output logic [2:0]  id_imm_sel,
  output logic        id_illegal
`ifdef IFD_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [2:0]  dec_sel;
  logic        dec_illegal;

  // Format select for the word arriving from memory, registered with it on load
  always_comb begin
    dec_sel     = 3'b000;
    dec_illegal = 1'b0;
    case (imem_rdata[6:0])
      7'b0010011, 7'b0000011, 7'b1100111,
      7'b1110011, 7'b0110011: dec_sel = 3'b000;
      7'b0100011:             dec_sel = 3'b001;
      7'b1100011:             dec_sel = 3'b010;
      7'b0110111, 7'b0010111: dec_sel = 3'b011;
      7'b1101111:             dec_sel = 3'b100;
      default:                dec_illegal = 1'b1;
    endcase
  end

  assign imem_req     = (state == FETCH);
  assign imem_addr    = pc;
  assign id_imm_field = id_instr[31:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      id_valid   <= 1'b0;
      id_pc      <= 32'h0;
      id_instr   <= 32'h0;
      id_imm_sel <= 3'b000;
      id_illegal <= 1'b0;
    end else if (redirect_valid) begin
      // A fetch that is still unanswered must drain its response before refetching
      pc       <= redirect_pc & 32'hFFFF_FFFC;
      id_valid <= 1'b0;
      case (state)
        FETCH, DRAIN: state <= imem_valid ? FETCH : DRAIN;
        default:      state <= FETCH;
      endcase
    end else begin
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (imem_valid) begin
            id_pc      <= pc;
            id_instr   <= imem_rdata;
            id_imm_sel <= dec_sel;
            id_illegal <= dec_illegal;
            id_valid   <= 1'b1;
            pc         <= pc + 32'd4;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (id_valid && id_ready) begin
            id_valid <= 1'b0;
            state    <= FETCH;
          end
        end
        default: begin
          if (imem_valid) state <= FETCH;
        end
      endcase
    end
  end

`ifdef IFD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (state == FETCH && imem_valid && !redirect_valid)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (id_valid && !id_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage with a scoreboard of expected IF/ID
// contents; perf counter checks are compiled in when IFD_PERF_EN is defined.
module tb_fetch_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [24:0] id_imm_field;
  logic [2:0]  id_imm_sel;
  logic        id_illegal;
`ifdef IFD_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t expQ[$];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_decode_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instr(id_instr), .id_imm_field(id_imm_field),
    .id_imm_sel(id_imm_sel), .id_illegal(id_illegal)
`ifdef IFD_PERF_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] rdata,
                               input logic rv, input logic [31:0] rpc);
    imem_valid     = valid;
    imem_rdata     = rdata;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  // Waits (bounded) for a request, then checks its address
  task automatic waitReq(input logic [31:0] expAddr);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("imem_req_seen", {31'h0, imem_req}, 32'h1);
    checkOutput("imem_addr", imem_addr, expAddr);
  endtask

  task automatic respond(input logic [31:0] expPc, input logic [31:0] word, input int lat,
                         input logic [2:0] sel, input logic ill);
    exp_t e;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checkOutput("req_held", {31'h0, imem_req}, 32'h1);
      checkOutput("addr_stable", imem_addr, expPc);
    end
    applyStimulus(1'b1, word, 1'b0, 32'h0);
    e.pc = expPc; e.instr = word; e.sel = sel; e.ill = ill;
    expQ.push_back(e);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic checkHeld(input string tag);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = expQ[0];
      checkOutput({tag, "_id_valid"}, {31'h0, id_valid}, 32'h1);
      checkOutput({tag, "_id_pc"}, id_pc, e.pc);
      checkOutput({tag, "_id_instr"}, id_instr, e.instr);
      checkOutput({tag, "_imm_field"}, {7'h0, id_imm_field}, {7'h0, e.instr[31:7]});
      checkOutput({tag, "_imm_sel"}, {29'h0, id_imm_sel}, {29'h0, e.sel});
      checkOutput({tag, "_illegal"}, {31'h0, id_illegal}, {31'h0, e.ill});
    end
  endtask

  task automatic accept();
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    if (expQ.size() > 0) void'(expQ.pop_front());
    checkOutput("id_valid_after_xfer", {31'h0, id_valid}, 32'h0);
  endtask

  logic [31:0] words [8] = '{32'h00112623, 32'h00208463, 32'h123450B7, 32'h008000EF,
                             32'hFFFFFFFF, 32'h00000000, 32'h0000A083, 32'h00000010};
  logic [2:0]  sels  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
  logic        ills  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    id_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_imem_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_id_valid", {31'h0, id_valid}, 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    checkOutput("rst_imm_sel", {29'h0, id_imm_sel}, 32'h0);
    checkOutput("rst_illegal", {31'h0, id_illegal}, 32'h0);
    rst_n = 1'b1;
    checkOutput("boot_imem_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);

    // addi with same-cycle response, then 5 stall cycles
    waitReq(32'h0);
    respond(32'h0, 32'h00500093, 0, 3'b000, 1'b0);
    checkHeld("addi");
    checkOutput("addi_imm_const", {7'h0, id_imm_field}, {7'h0, 25'h000A001});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkHeld("stall");
      checkOutput("stall_no_req", {31'h0, imem_req}, 32'h0);
    end
    accept();
    waitReq(32'h4);

    // Decode table, varying memory latency
    for (int i = 0; i < 8; i++) begin
      waitReq(32'h4 + 32'(i) * 32'h4);
      respond(32'h4 + 32'(i) * 32'h4, words[i], i % 3, sels[i], ills[i]);
      checkHeld("decode");
      accept();
    end

    // Redirect one cycle into a latency-3 fetch: stale response is drained
    waitReq(32'h24);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00000102);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("drain_no_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("drain_id_valid", {31'h0, id_valid}, 32'h0);
    waitReq(32'h100);
    checkOutput("post_drain_id_valid", {31'h0, id_valid}, 32'h0);

    // Redirect while holding drops the instruction; PC wraps past 2^32
    respond(32'h100, 32'h00500093, 0, 3'b000, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hFFFFFFFF);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    void'(expQ.pop_back());
    checkOutput("hold_redirect_drop", {31'h0, id_valid}, 32'h0);
    waitReq(32'hFFFFFFFC);
    respond(32'hFFFFFFFC, 32'h00208463, 1, 3'b010, 1'b0);
    checkHeld("wrap");
    accept();
    waitReq(32'h0);

    // Redirect coinciding with a response discards it
    applyStimulus(1'b1, 32'h00112623, 1'b1, 32'h00000040);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("fetch_redirect_id_valid", {31'h0, id_valid}, 32'h0);
    waitReq(32'h40);

    // Async reset mid-request; response during BOOT is ignored
    #2 rst_n = 1'b0;
    #1 checkOutput("async_rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("async_rst_id_valid", {31'h0, id_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 32'h00500093, 1'b0, 32'h0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("boot_ignore_id_valid", {31'h0, id_valid}, 32'h0);
    waitReq(32'h0);

    // Three instructions, the first held for two backpressure cycles
    for (int i = 0; i < 3; i++) begin
      waitReq(32'(i) * 32'h4);
      respond(32'(i) * 32'h4, 32'h00500093, 1, 3'b000, 1'b0);
      checkHeld("perf_run");
      if (i == 0) repeat (2) @(negedge clk);
      accept();
    end
`ifdef IFD_PERF_EN
    checkOutput("perf_fetch_cnt", perf_fetch_cnt, 32'd3);
    checkOutput("perf_stall_cnt", perf_stall_cnt, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
